// File: rtl/l8_ling_mod_subtractor_if.sv
// Handshake bundle for l8_ling_mod_subtractor: operand side (in_*, a, b) and
// result side (out_*, diff, zero).
interface l8_ling_mod_subtractor_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       zero;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, zero
  );
endinterface

// File: rtl/l8_ling_mod_subtractor.sv
// Three-stage modulo-255 subtractor (a + ~b, end-around carry via cyclic Ling recurrence).
// Define L8_MOD_NORM_EN to present a zero result as 0x00 instead of 0xFF.
module l8_ling_mod_subtractor (
  input  logic                          clk,
  input  logic                          rst,
  l8_ling_mod_subtractor_if.slave       bus
);

  logic       v1_q, v2_q, v3_q;
  logic       ld1, ld2, ld3;

  logic [7:0] g1_q, p1_q, x1_q;
  logic [7:0] g1_d, p1_d, x1_d;

  logic [7:0] h2_q, pr2_q, p2_q, x2_q;
  logic [7:0] h2_d, pr2_d;

  logic [7:0] diff_q, diff_d;
  logic       zero_q, zero_d;

  logic [7:0] hh, cy, raw;

  // Each stage advances when empty or when the stage ahead of it advances.
  always_comb begin
    ld3 = !v3_q || bus.out_ready;
    ld2 = !v2_q || ld3;
    ld1 = !v1_q || ld2;
  end

  assign bus.in_ready  = ld1 && !rst;
  assign bus.out_valid = v3_q;
  assign bus.diff      = diff_q;
  assign bus.zero      = zero_q;

  always_comb begin
    g1_d = bus.a & ~bus.b;
    p1_d = bus.a | ~bus.b;
    x1_d = bus.a ^ ~bus.b;
  end

  always_comb begin
    h2_d  = '0;
    pr2_d = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      h2_d[i]  = g1_q[i] | g1_q[(i + 7) % 8];
      pr2_d[i] = p1_q[i] & p1_q[(i + 7) % 8];
    end
  end

  // Ling H[i] = g[i] | c[i-1]; each Pr1 term spans two bits, so four terms
  // close the 8-bit ring. Carry out of bit i is p[i] & H[i].
  always_comb begin
    hh  = '0;
    cy  = '0;
    raw = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      hh[i] = h2_q[i]
            | (pr2_q[(i + 7) % 8] & h2_q[(i + 6) % 8])
            | (pr2_q[(i + 7) % 8] & pr2_q[(i + 5) % 8] & h2_q[(i + 4) % 8])
            | (pr2_q[(i + 7) % 8] & pr2_q[(i + 5) % 8] & pr2_q[(i + 3) % 8]
               & h2_q[(i + 2) % 8]);
    end
    for (int unsigned i = 0; i < 8; i++) begin
      cy[i] = p2_q[i] & hh[i];
    end
    for (int unsigned i = 0; i < 8; i++) begin
      raw[i] = x2_q[i] ^ cy[(i + 7) % 8];
    end
  end

  always_comb begin
`ifdef L8_MOD_NORM_EN
    diff_d = (raw == 8'hFF) ? 8'h00 : raw;
`else
    diff_d = raw;
`endif
    zero_d = (raw == 8'h00) || (raw == 8'hFF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      g1_q   <= '0;
      p1_q   <= '0;
      x1_q   <= '0;
      h2_q   <= '0;
      pr2_q  <= '0;
      p2_q   <= '0;
      x2_q   <= '0;
      diff_q <= '0;
      zero_q <= 1'b0;
    end else begin
      if (ld1) begin
        v1_q <= bus.in_valid;
        if (bus.in_valid) begin
          g1_q <= g1_d;
          p1_q <= p1_d;
          x1_q <= x1_d;
        end
      end
      if (ld2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          h2_q  <= h2_d;
          pr2_q <= pr2_d;
          p2_q  <= p1_q;
          x2_q  <= x1_q;
        end
      end
      if (ld3) begin
        v3_q <= v2_q;
        if (v2_q) begin
          diff_q <= diff_d;
          zero_q <= zero_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_l8_ling_mod_subtractor.sv
// Directed and exhaustive checks for l8_ling_mod_subtractor; honours L8_MOD_NORM_EN.
module tb_l8_ling_mod_subtractor;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

`ifdef L8_MOD_NORM_EN
  localparam logic [7:0] ZREP = 8'h00;
`else
  localparam logic [7:0] ZREP = 8'hFF;
`endif

  l8_ling_mod_subtractor_if bus ();

  l8_ling_mod_subtractor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_diff(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] d;
    s = {1'b0, a} + {1'b0, ~b};
    d = s[7:0] + {7'b0, s[8]};
`ifdef L8_MOD_NORM_EN
    if (d == 8'hFF) d = 8'h00;
`endif
    return d;
  endfunction

  function automatic logic ref_zero(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] d;
    s = {1'b0, a} + {1'b0, ~b};
    d = s[7:0] + {7'b0, s[8]};
    return (d == 8'h00) || (d == 8'hFF);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  // Single operand, out_ready high: result must appear in the third cycle after acceptance.
  task automatic send_latency(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] exp_d, input logic exp_z);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = 1'b1;
    #1;
    check({tag, " in_ready"}, {7'b0, bus.in_ready}, 8'h01);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, " valid c1"}, {7'b0, bus.out_valid}, 8'h00);
    @(negedge clk);
    check({tag, " valid c2"}, {7'b0, bus.out_valid}, 8'h00);
    @(negedge clk);
    check({tag, " valid c3"}, {7'b0, bus.out_valid}, 8'h01);
    check({tag, " diff"}, bus.diff, exp_d);
    check({tag, " zero"}, {7'b0, bus.zero}, {7'b0, exp_z});
    @(negedge clk);
    check({tag, " drained"}, {7'b0, bus.out_valid}, 8'h00);
  endtask

  logic [7:0] pa [8];
  logic [7:0] pb [8];
  int         sent, rcv;
  logic       saw_full;
  logic       exp_rdy;

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst in_ready", {7'b0, bus.in_ready}, 8'h00);
    check("rst out_valid", {7'b0, bus.out_valid}, 8'h00);
    check("rst diff", bus.diff, 8'h00);
    check("rst zero", {7'b0, bus.zero}, 8'h00);
    rst = 1'b0;
    #1;
    check("post-rst in_ready", {7'b0, bus.in_ready}, 8'h01);

    // Directed vectors, hand-computed
    send_latency("basic 05-03", 8'h05, 8'h03, 8'h02, 1'b0);
    send_latency("wrap 03-05", 8'h03, 8'h05, 8'hFD, 1'b0);
    send_latency("wrap 00-01", 8'h00, 8'h01, 8'hFE, 1'b0);
    send_latency("zero 40-40", 8'h40, 8'h40, ZREP, 1'b1);
    send_latency("zero FF-00", 8'hFF, 8'h00, ZREP, 1'b1);

    // Backpressure: 8 pairs back-to-back, out_ready low in cycles 2..6
    for (int i = 0; i < 8; i++) begin
      pa[i] = 8'($urandom_range(0, 255));
      pb[i] = 8'($urandom_range(0, 255));
    end
    sent     = 0;
    rcv      = 0;
    saw_full = 1'b0;
    for (int c = 0; c < 60 && rcv < 8; c++) begin
      @(negedge clk);
      bus.out_ready = !(c >= 2 && c <= 6);
      bus.in_valid  = (sent < 8);
      if (sent < 8) begin
        bus.a = pa[sent];
        bus.b = pb[sent];
      end
      #1;
      exp_rdy = !((sent - rcv) == 3 && !bus.out_ready);
      check("bp in_ready", {7'b0, bus.in_ready}, {7'b0, exp_rdy});
      if (!bus.in_ready) saw_full = 1'b1;
      if (bus.out_valid) begin
        if (rcv < 8) begin
          check($sformatf("bp diff[%0d]", rcv), bus.diff, ref_diff(pa[rcv], pb[rcv]));
          check($sformatf("bp zero[%0d]", rcv), {7'b0, bus.zero},
                {7'b0, ref_zero(pa[rcv], pb[rcv])});
        end else begin
          check("bp extra result", {7'b0, bus.out_valid}, 8'h00);
        end
      end
      if (bus.out_valid && bus.out_ready) rcv++;
      if (bus.in_valid && bus.in_ready) sent++;
    end
    check("bp all received", 8'(rcv), 8'd8);
    check("bp in_ready dropped", {7'b0, saw_full}, 8'h01);
    @(negedge clk);
    bus.in_valid = 1'b0;

    // Reset mid-flight: two operands accepted, then one reset cycle
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = 8'h33;
    bus.b         = 8'h11;
    @(negedge clk);
    bus.a         = 8'h77;
    bus.b         = 8'h22;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    rst           = 1'b1;
    #1;
    check("midrst in_ready", {7'b0, bus.in_ready}, 8'h00);
    @(negedge clk);
    check("midrst out_valid", {7'b0, bus.out_valid}, 8'h00);
    check("midrst diff", bus.diff, 8'h00);
    check("midrst zero", {7'b0, bus.zero}, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst no stale", {7'b0, bus.out_valid}, 8'h00);
    end
    send_latency("after rst 10-20", 8'h10, 8'h20, 8'hEF, 1'b0);

    // Exhaustive at full throughput: pair n is checked three cycles after it is driven
    bus.out_ready = 1'b1;
    for (int n = 0; n < 65536 + 3; n++) begin
      logic [15:0] m;
      @(negedge clk);
      if (n < 65536) begin
        m            = 16'(n);
        bus.in_valid = 1'b1;
        bus.a        = m[15:8];
        bus.b        = m[7:0];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (n >= 3) begin
        m = 16'(n - 3);
        if (bus.out_valid !== 1'b1 || bus.diff !== ref_diff(m[15:8], m[7:0])
            || bus.zero !== ref_zero(m[15:8], m[7:0])) begin
          check($sformatf("exh valid %02h-%02h", m[15:8], m[7:0]),
                {7'b0, bus.out_valid}, 8'h01);
          check($sformatf("exh diff %02h-%02h", m[15:8], m[7:0]),
                bus.diff, ref_diff(m[15:8], m[7:0]));
          check($sformatf("exh zero %02h-%02h", m[15:8], m[7:0]),
                {7'b0, bus.zero}, {7'b0, ref_zero(m[15:8], m[7:0])});
        end else begin
          n_checks++;
        end
      end
    end
    @(negedge clk);
    check("exh drained", {7'b0, bus.out_valid}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
